// File: rtl/load_seq_pkg.sv
// Shared types, select codes and phase-order helper for the layer load sequencer.
package load_seq_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WGT,
    LOAD_BIAS,
    LOAD_IFM,
    DONE
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IFM  = 2'b01;
  localparam logic [1:0] SEL_WGT  = 2'b10;
  localparam logic [1:0] SEL_BIAS = 2'b11;

  typedef struct packed {
    cnt_t wgt;
    cnt_t bias;
    cnt_t ifm;
  } lens_t;

  // First phase after cur (order WGT->BIAS->IFM) with a nonzero length, else DONE.
  function automatic state_t next_phase(state_t cur, cnt_t wgt_len, cnt_t bias_len, cnt_t ifm_len);
    state_t n;
    n = DONE;
    if ((cur == IDLE || cur == LOAD_WGT || cur == LOAD_BIAS) && ifm_len != '0) n = LOAD_IFM;
    if ((cur == IDLE || cur == LOAD_WGT) && bias_len != '0) n = LOAD_BIAS;
    if (cur == IDLE && wgt_len != '0) n = LOAD_WGT;
    return n;
  endfunction

endpackage

// File: rtl/load_sequencer_if.sv
// Stream handshake and demux/buffer write bus between the sequencer and its neighbours.
interface load_sequencer_if;
  import load_seq_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       wr_en_wgt;
  logic       wr_en_bias;
  logic       wr_en_ifm;
  cnt_t       wr_addr;

  modport master (
    input  in_valid,
    output in_ready, sel, wr_en_wgt, wr_en_bias, wr_en_ifm, wr_addr
  );

  modport slave (
    output in_valid,
    input  in_ready, sel, wr_en_wgt, wr_en_bias, wr_en_ifm, wr_addr
  );
endinterface

// File: rtl/load_sequencer_phase_counter.sv
// Per-phase word counter with clear priority and a last-word flag.
module phase_counter
  import load_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  input  cnt_t len,
  output cnt_t count,
  output logic terminal_c
);

  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CNT_WIDTH'(1);
  end

  assign terminal_c = (count == len - CNT_WIDTH'(1));

endmodule

// File: rtl/load_sequencer.sv
// Layer load sequencer: steers the off-chip stream to WGT, BIAS then IFM buffers.
// Optional starved-cycle counter built when LOAD_SEQ_PERF_EN is defined.
module load_sequencer
  import load_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  cnt_t                wgt_len,
  input  cnt_t                bias_len,
  input  cnt_t                ifm_len,
  load_sequencer_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         stall_cnt
);

  state_t state_q, state_d;
  lens_t  lens_q;
  cnt_t   cur_len, cnt_q;
  logic   cnt_inc, cnt_clr, cnt_last_c;
  logic   load_active;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lengths are captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)                      lens_q <= '0;
    else if (state_q == IDLE && start) lens_q <= '{wgt: wgt_len, bias: bias_len, ifm: ifm_len};
  end

  always_comb begin
    cur_len = '0;
    case (state_q)
      LOAD_WGT:  cur_len = lens_q.wgt;
      LOAD_BIAS: cur_len = lens_q.bias;
      LOAD_IFM:  cur_len = lens_q.ifm;
      default:   cur_len = '0;
    endcase
  end

  assign load_active = (state_q == LOAD_WGT) || (state_q == LOAD_BIAS) || (state_q == LOAD_IFM);

  phase_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .len        (cur_len),
    .count      (cnt_q),
    .terminal_c (cnt_last_c)
  );

  // Next-state and output decode; abort outranks a same-cycle word.
  always_comb begin
    state_d         = state_q;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    bus.in_ready    = 1'b0;
    bus.sel         = SEL_NONE;
    bus.wr_en_wgt   = 1'b0;
    bus.wr_en_bias  = 1'b0;
    bus.wr_en_ifm   = 1'b0;
    bus.wr_addr     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = next_phase(IDLE, wgt_len, bias_len, ifm_len);
        end
      end
      LOAD_WGT, LOAD_BIAS, LOAD_IFM: begin
        busy         = 1'b1;
        bus.in_ready = 1'b1;
        case (state_q)
          LOAD_WGT:  bus.sel = SEL_WGT;
          LOAD_BIAS: bus.sel = SEL_BIAS;
          default:   bus.sel = SEL_IFM;
        endcase
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (bus.in_valid) begin
          bus.wr_en_wgt  = (state_q == LOAD_WGT);
          bus.wr_en_bias = (state_q == LOAD_BIAS);
          bus.wr_en_ifm  = (state_q == LOAD_IFM);
          if (cnt_last_c) begin
            cnt_clr = 1'b1;
            state_d = next_phase(state_q, lens_q.wgt, lens_q.bias, lens_q.ifm);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LOAD_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Starved load cycles, saturating; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       stall_q <= '0;
    else if (state_q == IDLE && start)                stall_q <= '0;
    else if (load_active && !bus.in_valid && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
